// File: rtl/multdiv_issue_ctrl.sv
// multdiv_issue_ctrl: pipeline-side initiator for the multi-cycle multiply/divide
// unit. Holds one request, fires a single start pulse with stable operands,
// stalls upstream until the unit answers (or the watchdog fires) and produces
// exactly one register-file writeback per completed operation.
module multdiv_issue_ctrl #(
  parameter int unsigned RSTATUS_REG = 30,
  parameter int unsigned EXC_MULT    = 4,
  parameter int unsigned EXC_DIV     = 5,
  parameter int unsigned EXC_TIMEOUT = 6,
  parameter int unsigned TIMEOUT     = 48
) (
  input  logic        clock,
  input  logic        ctrl_reset_n,
  input  logic        op_valid,
  input  logic        op_is_div,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [4:0]  op_rd,
  output logic        op_ready,
  input  logic        abort,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  output logic [31:0] data_operandA,
  output logic [31:0] data_operandB,
  input  logic [31:0] data_result,
  input  logic        data_exception,
  input  logic        data_resultRDY,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic [5:0]  busy_cycles
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} state_t;

  localparam logic [4:0]  STATUS_RD    = 5'(RSTATUS_REG);
  localparam logic [31:0] MULT_CODE    = 32'(EXC_MULT);
  localparam logic [31:0] DIV_CODE     = 32'(EXC_DIV);
  localparam logic [31:0] TIMEOUT_CODE = 32'(EXC_TIMEOUT);
  localparam logic [5:0]  TIMEOUT_CNT  = 6'(TIMEOUT);
  localparam logic [5:0]  BUSY_MAX     = 6'd63;

  state_t      state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [4:0]  rd_q, rd_d;
  logic        is_div_q, is_div_d;
  logic [5:0]  busy_q, busy_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [5:0]  busy_inc;

  // Operands go straight from the latched request so they are stable through
  // the start pulse and remain visible until the next accept.
  assign data_operandA = a_q;
  assign data_operandB = b_q;
  assign busy_cycles   = busy_q;
  assign wb_rd         = wb_rd_q;
  assign wb_data       = wb_data_q;

  // State and datapath registers; reset drops any in-flight op silently.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      rd_q      <= '0;
      is_div_q  <= 1'b0;
      busy_q    <= '0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      rd_q      <= rd_d;
      is_div_q  <= is_div_d;
      busy_q    <= busy_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
    end
  end

  // Next-state and output decode; abort beats RDY, and RDY beats the watchdog.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    rd_d      = rd_q;
    is_div_d  = is_div_q;
    busy_d    = busy_q;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    op_ready  = 1'b0;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    stall     = 1'b1;
    wb_valid  = 1'b0;
    busy_inc  = (busy_q == BUSY_MAX) ? busy_q : busy_q + 6'd1;

    case (state_q)
      IDLE: begin
        stall    = 1'b0;
        op_ready = ~abort;
        if (op_valid && !abort) begin
          a_d      = op_a;
          b_d      = op_b;
          rd_d     = op_rd;
          is_div_d = op_is_div;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        ctrl_DIV  = is_div_q;
        ctrl_MULT = ~is_div_q;
        busy_d    = '0;
        state_d   = abort ? IDLE : WAIT;
      end
      WAIT: begin
        busy_d = busy_inc;
        if (abort) begin
          state_d = IDLE;
        end else if (data_resultRDY) begin
          state_d = WB;
          if (data_exception) begin
            wb_rd_d   = STATUS_RD;
            wb_data_d = is_div_q ? DIV_CODE : MULT_CODE;
          end else begin
            wb_rd_d   = rd_q;
            wb_data_d = data_result;
          end
        end else if (busy_inc >= TIMEOUT_CNT) begin
          state_d   = WB;
          wb_rd_d   = STATUS_RD;
          wb_data_d = TIMEOUT_CODE;
        end
      end
      WB: begin
        wb_valid = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// tb_multdiv_issue_ctrl: plays the role of the multdiv unit and the pipeline,
// predicting each writeback from the arithmetic of the request and the cycle at
// which the unit answers.
module tb_multdiv_issue_ctrl;

  localparam int TMO = 48;

  logic        clock = 1'b0;
  logic        ctrl_reset_n = 1'b0;
  logic        op_valid = 1'b0;
  logic        op_is_div = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [4:0]  op_rd = '0;
  logic        op_ready;
  logic        abort = 1'b0;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result = '0;
  logic        data_exception = 1'b0;
  logic        data_resultRDY = 1'b0;
  logic        stall;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [5:0]  busy_cycles;

  int checks = 0;
  int errors = 0;

  multdiv_issue_ctrl dut (
    .clock(clock), .ctrl_reset_n(ctrl_reset_n),
    .op_valid(op_valid), .op_is_div(op_is_div), .op_a(op_a), .op_b(op_b),
    .op_rd(op_rd), .op_ready(op_ready), .abort(abort),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .data_result(data_result), .data_exception(data_exception),
    .data_resultRDY(data_resultRDY), .stall(stall), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .wb_data(wb_data), .busy_cycles(busy_cycles)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clock = ~clock;

  // What the multdiv unit computes: signed product / quotient and its exception.
  function automatic void unit_model(input logic is_div, input logic [31:0] a,
                                     input logic [31:0] b, output logic [31:0] res,
                                     output logic exc);
    longint sa, sb, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (is_div) begin
      exc = (b == 32'd0);
      res = exc ? 32'd0 : 32'(sa / sb);
    end else begin
      p   = sa * sb;
      exc = (p > 64'sd2147483647) || (p < -64'sd2147483648);
      res = 32'(p);
    end
  endfunction

  // One full operation. rdy_at: WAIT cycle (1-based) where the unit answers,
  // 0 = never. abort_at: WAIT cycle to abort in, -1 = abort during ISSUE, 0 = none.
  task automatic run_op(input logic is_div, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int rdy_at, input int abort_at,
                        input logic rdy_in_issue, input logic abort_in_wb);
    logic [31:0] res, e_data;
    logic        exc;
    logic [4:0]  e_rd;
    int          last;
    bit          timed_out, aborted;
    unit_model(is_div, a, b, res, exc);
    timed_out = (rdy_at == 0) || (rdy_at > TMO);
    last      = timed_out ? TMO : rdy_at;
    aborted   = (abort_at < 0) || (abort_at > 0 && abort_at <= last);
    if (abort_at > 0 && aborted) last = abort_at;
    if (timed_out) begin
      e_rd = 5'd30; e_data = 32'd6;
    end else if (exc) begin
      e_rd = 5'd30; e_data = is_div ? 32'd5 : 32'd4;
    end else begin
      e_rd = rd; e_data = res;
    end

    @(negedge clock);
    op_valid = 1'b1; op_is_div = is_div; op_a = a; op_b = b; op_rd = rd;
    abort = 1'b0; data_resultRDY = 1'b0;
    #1;
    checks++;
    if ({op_ready, stall, wb_valid} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL accept_idle got ready/stall/wb=%b expected 100", {op_ready, stall, wb_valid});
    end

    // ISSUE: junk request held upstream, stray RDY and optional abort.
    @(negedge clock);
    op_a = ~a; op_b = ~b; op_rd = ~rd; op_is_div = ~is_div;
    data_resultRDY = rdy_in_issue; data_exception = 1'b1; data_result = $urandom;
    abort = (abort_at < 0);
    #1;
    checks++;
    if ({ctrl_MULT, ctrl_DIV, stall, op_ready, wb_valid} !== {~is_div, is_div, 3'b100}) begin
      errors++;
      $display("[TB] FAIL issue_pulse got mult/div/stall/ready/wb=%b expected %b",
               {ctrl_MULT, ctrl_DIV, stall, op_ready, wb_valid}, {~is_div, is_div, 3'b100});
    end
    checks++;
    if ({data_operandA, data_operandB} !== {a, b}) begin
      errors++;
      $display("[TB] FAIL issue_operands got %h %h expected %h %h", data_operandA, data_operandB, a, b);
    end

    if (abort_at >= 0) begin
      for (int k = 1; k <= last; k++) begin
        @(negedge clock);
        data_resultRDY = (k == rdy_at); data_exception = exc;
        data_result = (k == rdy_at) ? res : $urandom;
        abort = (k == abort_at);
        #1;
        checks++;
        if ({ctrl_MULT, ctrl_DIV, stall, op_ready, wb_valid, data_operandA} !== {5'b00100, a}) begin
          errors++;
          $display("[TB] FAIL wait_cycle_%0d got mult/div/stall/ready/wb=%b opA=%h expected 00100 %h",
                   k, {ctrl_MULT, ctrl_DIV, stall, op_ready, wb_valid}, data_operandA, a);
        end
      end
    end

    @(negedge clock);
    abort = aborted ? 1'b0 : abort_in_wb;
    op_valid = aborted ? 1'b0 : 1'b1;
    data_resultRDY = 1'b1; data_exception = 1'b0; data_result = $urandom;
    #1;
    if (aborted) begin
      checks++;
      if ({op_ready, stall, wb_valid} !== 3'b100) begin
        errors++;
        $display("[TB] FAIL abort_to_idle got ready/stall/wb=%b expected 100", {op_ready, stall, wb_valid});
      end
    end else begin
      checks++;
      if ({wb_valid, stall, op_ready} !== 3'b110) begin
        errors++;
        $display("[TB] FAIL wb_strobe got wb/stall/ready=%b expected 110", {wb_valid, stall, op_ready});
      end
      checks++;
      if ({wb_rd, wb_data} !== {e_rd, e_data}) begin
        errors++;
        $display("[TB] FAIL wb_value got rd=%0d data=%h expected rd=%0d data=%h", wb_rd, wb_data, e_rd, e_data);
      end
      checks++;
      if (busy_cycles !== 6'(last)) begin
        errors++;
        $display("[TB] FAIL busy_cycles got %0d expected %0d", busy_cycles, last);
      end
      @(negedge clock);
      op_valid = 1'b0; abort = 1'b0; data_resultRDY = 1'b0;
      #1;
      checks++;
      if ({wb_valid, stall, op_ready, wb_rd, wb_data} !== {3'b001, e_rd, e_data}) begin
        errors++;
        $display("[TB] FAIL post_wb got wb/stall/ready=%b rd=%0d data=%h expected 001 rd=%0d data=%h",
                 {wb_valid, stall, op_ready}, wb_rd, wb_data, e_rd, e_data);
      end
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({op_ready, ctrl_MULT, ctrl_DIV, stall, wb_valid} !== 5'b10000 ||
        {wb_rd, wb_data, data_operandA, data_operandB, busy_cycles} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_state got ctl=%b rd=%0d data=%h A=%h B=%h busy=%0d expected 10000 and zeros",
               {op_ready, ctrl_MULT, ctrl_DIV, stall, wb_valid}, wb_rd, wb_data,
               data_operandA, data_operandB, busy_cycles);
    end
    @(negedge clock);
    ctrl_reset_n = 1'b1;
  endtask

  task automatic test_mult_basic();
    run_op(1'b0, 32'd7, -32'sd6, 5'd3, 5, 0, 1'b0, 1'b0);
  endtask

  task automatic test_exceptions();
    run_op(1'b1, 32'd100, 32'd0, 5'd9, 34, 0, 1'b1, 1'b0);
    run_op(1'b0, 32'h7FFF_FFFF, 32'd2, 5'd12, 3, 0, 1'b0, 1'b1);
  endtask

  task automatic test_timeout();
    run_op(1'b1, 32'd81, 32'd9, 5'd7, 0, 0, 1'b0, 1'b0);
    // The unit answers in the same cycle the watchdog would expire.
    run_op(1'b1, 32'd81, 32'd9, 5'd7, TMO, 0, 1'b0, 1'b0);
  endtask

  task automatic test_abort();
    run_op(1'b1, 32'd1000, 32'd10, 5'd4, 34, 5, 1'b0, 1'b0);
    run_op(1'b0, 32'd3, 32'd4, 5'd1, 2, 0, 1'b0, 1'b0);
    run_op(1'b0, 32'd5, 32'd6, 5'd2, 4, -1, 1'b0, 1'b0);
    run_op(1'b1, 32'd50, 32'd5, 5'd8, 1, 0, 1'b1, 1'b1);
  endtask

  task automatic test_abort_idle();
    @(negedge clock);
    op_valid = 1'b1; abort = 1'b1; op_is_div = 1'b0; op_a = 32'd11; op_b = 32'd13; op_rd = 5'd6;
    #1;
    checks++;
    if (op_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_idle_ready got %b expected 0", op_ready);
    end
    @(negedge clock);
    op_valid = 1'b0; abort = 1'b0;
    #1;
    checks++;
    if ({stall, ctrl_MULT, ctrl_DIV, op_ready} !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL abort_idle_stay got stall/mult/div/ready=%b expected 0001",
               {stall, ctrl_MULT, ctrl_DIV, op_ready});
    end
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clock);
    op_valid = 1'b1; op_is_div = 1'b1; op_a = 32'h1234_5678; op_b = 32'd3; op_rd = 5'd15;
    @(negedge clock);
    op_valid = 1'b0;
    repeat (4) @(negedge clock);
    #2 ctrl_reset_n = 1'b0;
    #1;
    checks++;
    if ({op_ready, ctrl_MULT, ctrl_DIV, stall, wb_valid} !== 5'b10000 ||
        {wb_rd, wb_data, data_operandA, data_operandB, busy_cycles} !== '0) begin
      errors++;
      $display("[TB] FAIL async_reset got ctl=%b rd=%0d data=%h A=%h B=%h busy=%0d expected 10000 and zeros",
               {op_ready, ctrl_MULT, ctrl_DIV, stall, wb_valid}, wb_rd, wb_data,
               data_operandA, data_operandB, busy_cycles);
    end
    @(negedge clock);
    ctrl_reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      data_resultRDY = (k == 0); data_result = 32'hDEAD_BEEF;
      #1;
      checks++;
      if ({op_ready, wb_valid, stall} !== 3'b100) begin
        errors++;
        $display("[TB] FAIL after_reset_%0d got ready/wb/stall=%b expected 100", k, {op_ready, wb_valid, stall});
      end
      @(negedge clock);
    end
    data_resultRDY = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      logic        d;
      logic [31:0] a, b;
      logic [4:0]  rd;
      int          rdy, ab, r;
      d = 1'($urandom_range(0, 1));
      if (d) begin
        a = $urandom;
        b = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      end else begin
        a = 32'($urandom_range(0, 131071)) - 32'd65536;
        b = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 131071)) - 32'd65536;
      end
      rd = 5'($urandom_range(0, 31));
      r = $urandom_range(0, 7);
      if (r == 0) rdy = 0;
      else if (r == 1) rdy = $urandom_range(49, 60);
      else rdy = $urandom_range(1, 40);
      r = $urandom_range(0, 9);
      if (r == 0) ab = -1;
      else if (r < 3) ab = $urandom_range(1, 50);
      else ab = 0;
      run_op(d, a, b, rd, rdy, ab, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  // Scenario sequence and summary.
  initial begin
    test_reset();
    test_mult_basic();
    test_reset_mid_wait();
    test_exceptions();
    test_timeout();
    test_abort();
    test_abort_idle();
    test_random();
    repeat (2) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL global_timeout got still running expected finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule

// File: doc/multdiv_issue_ctrl.md
Name: multdiv_issue_ctrl

Overview:
- Pipeline-side initiator for the multi-cycle multiply/divide unit.
- Accepts a MULT/DIV request from decode/execute and holds it for the duration. Issues a one-cycle ctrl_MULT or ctrl_DIV pulse with stable operands, then stalls the pipeline until data_resultRDY.
- Produces a single register-file writeback: the result to rd, or the exception code to the status register.
- Adds a watchdog and an abort path so a lost or cancelled operation cannot hang the core.

Parameters:
- RSTATUS_REG, 30, register index written on exception
- EXC_MULT, 4, status code for multiply overflow
- EXC_DIV, 5, status code for divide-by-zero
- EXC_TIMEOUT, 6, status code when the watchdog expires
- TIMEOUT, 48, maximum WAIT cycles before the watchdog fires (must exceed the DIV latency of 34)

Ports:
- clock  in  1  system clock, rising edge
- ctrl_reset_n  in  1  asynchronous active-low reset
- op_valid  in  1  request present
- op_is_div  in  1  1=DIV, 0=MULT
- op_a  in  32  operand A
- op_b  in  32  operand B
- op_rd  in  5  destination register
- op_ready  out  1  request accepted this cycle when op_valid&op_ready
- abort  in  1  flush; cancel the in-flight op
- ctrl_MULT  out  1  start pulse to the multdiv unit
- ctrl_DIV  out  1  start pulse to the multdiv unit
- data_operandA  out  32  operand to the multdiv unit
- data_operandB  out  32  operand to the multdiv unit
- data_result  in  32  from the multdiv unit
- data_exception  in  1  from the multdiv unit
- data_resultRDY  in  1  from the multdiv unit
- stall  out  1  freeze upstream pipeline
- wb_valid  out  1  one-cycle writeback strobe
- wb_rd  out  5  writeback register
- wb_data  out  32  writeback value
- busy_cycles  out  6  WAIT-cycle count of the current or last op

Behaviour:
- Reset (async, ctrl_reset_n=0):
  - state=IDLE; op_ready=1.
  - All other outputs are 0: ctrl_MULT, ctrl_DIV, stall, wb_valid, wb_rd, wb_data, data_operandA/B, busy_cycles.
  - Reset mid-operation drops the op silently; no wb_valid is produced.
- States: IDLE, ISSUE, WAIT, WB.
- IDLE:
  - op_ready=1, stall=0.
  - On op_valid, latch op_a, op_b, op_rd and op_is_div into internal registers, then go to ISSUE.
- ISSUE (exactly 1 cycle):
  - Drive ctrl_DIV=kind or ctrl_MULT=~kind; exactly one is high. data_operandA/B are driven from the latched registers.
  - busy_cycles is cleared. Go to WAIT.
- data_operandA/B hold their latched values from ISSUE until the next accept. They must be stable in ISSUE because the unit captures them on the falling edge during the pulse.
- WAIT:
  - busy_cycles increments every cycle and saturates at 63.
  - data_resultRDY=1 goes to WB.
    - data_exception=0: wb_rd=latched rd, wb_data=data_result.
    - data_exception=1: wb_rd=RSTATUS_REG, wb_data=EXC_DIV if div else EXC_MULT.
  - busy_cycles reaching TIMEOUT with no RDY goes to WB with wb_rd=RSTATUS_REG, wb_data=EXC_TIMEOUT.
  - RDY wins over timeout in the same cycle.
- WB (exactly 1 cycle): wb_valid=1, then go to IDLE. wb_rd/wb_data hold until the next WB.
- stall=1 in ISSUE, WAIT and WB; op_ready=0 in those states.
- A request arriving while not IDLE is not accepted; upstream holds it.
- data_resultRDY is honoured only in WAIT. A pulse seen in IDLE, ISSUE or WB is ignored, which covers a stale RDY from an aborted op.
- abort:
  - In ISSUE or WAIT: go to IDLE next cycle with no wb_valid. The ctrl pulse is still driven if abort coincides with ISSUE.
  - In WB: wb_valid still fires (the op is already retired).
  - In IDLE: the concurrent op_valid is not accepted.
- A new op may be accepted the cycle after an abort. Its start pulse restarts the unit's counter, so the old RDY cannot reach the new op.
- Back-to-back: WB→IDLE→accept gives minimum spacing of 4 cycles between start pulses.
- Latency from accept to wb_valid = unit latency + 3 cycles (accept, ISSUE, WB).

Test Plan:
- MULT 7×(-6), rd=3 → single ctrl_MULT pulse carrying A=7, B=-6; stall held; one wb_valid with wb_rd=3, wb_data=0xFFFFFFD6; op_ready returns the next cycle.
- DIV 100/0, rd=9 → ctrl_DIV pulse; RDY with exception; wb_rd=30, wb_data=5; no write to r9.
- MULT 0x7FFFFFFF×2 → exception; wb_rd=30, wb_data=4.
- DIV with RDY tied low → after 48 WAIT cycles, wb_valid with wb_rd=30, wb_data=6.
- abort 5 cycles into a DIV, then a stray RDY pulse while IDLE → no wb_valid. A new MULT 3×4, rd=1, accepted immediately → wb_data=12 to r1.
- ctrl_reset_n low mid-WAIT → all outputs 0 asynchronously; after release, op_ready=1 and no wb_valid appears.
